airi5c_uart_tx: RTL and testbench

UART transmitter. Buffers 9-bit words written by the bus interface in a FIFO and serialises them onto `tx` as asynchronous frames: start bit, 5–9 data bits LSB first, optional parity, and 1/1.5/2 stop bits. It uses the same `ctrl_reg` layout as the UART receiver, so one control register drives both directions, and its `cts` input connects to the remote receiver's `rts`.

---
 rtl/airi5c_uart_tx_pkg.sv | 57 +++++
 rtl/airi5c_uart_fifo.sv | 60 ++++++
 rtl/airi5c_uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_airi5c_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/airi5c_uart_tx_pkg.sv
// Shared UART field encodings, control-register layout and frame helper functions.
// Used by airi5c_uart_tx (optional break support: AIRI5C_UART_TX_BREAK_EN).
package airi5c_uart_tx_pkg;

  localparam logic [1:0] UART_PARITY_NONE  = 2'b00;
  localparam logic [1:0] UART_PARITY_EVEN  = 2'b01;
  localparam logic [1:0] UART_PARITY_ODD   = 2'b10;

  localparam logic [1:0] UART_STOP_1       = 2'b00;
  localparam logic [1:0] UART_STOP_1_5     = 2'b01;
  localparam logic [1:0] UART_STOP_2       = 2'b10;

  localparam logic       UART_FLOW_CTRL_ON = 1'b1;

  localparam int UART_DATA_WIDTH = 9;
  localparam int UART_CNT_WIDTH  = 25;

  // Same layout the receiver decodes, so one register serves both directions.
  typedef struct packed {
    logic [2:0]  data_bits;
    logic [1:0]  parity;
    logic [1:0]  stop_bits;
    logic        flow_ctrl;
    logic [23:0] baud_reg;
  } uart_ctrl_t;

  function automatic logic [3:0] frame_data_bits(input logic [2:0] data_bits);
    logic [3:0] n;
    if (data_bits > 3'd4) n = 4'd9;
    else                  n = {1'b0, data_bits} + 4'd5;
    return n;
  endfunction

  function automatic logic [24:0] stop_cycles(input logic [1:0]  stop_bits,
                                              input logic [23:0] baud);
    logic [24:0] b;
    logic [24:0] l;
    b = {1'b0, baud};
    case (stop_bits)
      UART_STOP_1_5: l = b + (b >> 1);
      UART_STOP_2:   l = b << 1;
      default:       l = b;
    endcase
    return l;
  endfunction

  function automatic logic parity_bit(input logic [1:0] parity,
                                      input logic [8:0] data,
                                      input logic [3:0] nbits);
    logic [8:0] mask;
    logic       p;
    mask = 9'h1FF >> (4'd9 - nbits);
    p    = ^(data & mask);
    return (parity == UART_PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/airi5c_uart_fifo.sv
// First-word-fall-through FIFO used as the UART transmit buffer.
// Head word is valid whenever empty is low; clear flushes and wins over push.
module airi5c_uart_fifo #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   size,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow_error
);

  localparam int                  DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_size;
  logic                  w_pop;
  logic                  w_push;

  assign empty    = (r_size == '0);
  assign full     = (r_size == FULL_LEVEL);
  assign size     = r_size;
  assign data_out = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign w_pop          = pop && !empty;
  assign w_push         = push && !clear && (!full || w_pop);
  assign overflow_error = push && full && !w_pop;

  always_ff @(posedge clk) begin
    if (!n_reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_size   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_size <= r_size + 1'b1;
        2'b01:   r_size <= r_size - 1'b1;
        default: r_size <= r_size;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

endmodule

// File: rtl/airi5c_uart_tx.sv
// UART transmitter: FIFO-buffered words serialised as start/data/parity/stop frames.
// Define AIRI5C_UART_TX_BREAK_EN to add the send_break input (line held low in IDLE).
module airi5c_uart_tx
  import airi5c_uart_tx_pkg::*;
#(
  parameter int STACK_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      clear,
  output logic                      tx,
  input  logic                      cts,
  input  logic [31:0]               ctrl_reg,
  input  logic                      push,
  input  logic [8:0]                data_in,
  output logic [STACK_ADDR_WIDTH:0] size,
  output logic                      empty,
  output logic                      full,
  output logic                      busy,
  output logic                      overflow_error
`ifdef AIRI5C_UART_TX_BREAK_EN
  ,
  input  logic                      send_break
`endif
);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  uart_ctrl_t  w_ctrl;
  logic [8:0]  w_fifo_data;
  logic        w_empty;
  logic        w_start;
  logic        w_break;
  logic        w_bit_end;

  state_t      r_state;
  logic        r_tx;
  logic        r_busy;
  logic [8:0]  r_shift;
  logic [24:0] r_cnt;
  logic [3:0]  r_bit_idx;
  logic [3:0]  r_nbits;
  logic        r_par_en;
  logic        r_par_bit;
  logic [24:0] r_baud_last;
  logic [24:0] r_stop_last;

  assign w_ctrl = uart_ctrl_t'(ctrl_reg);

`ifdef AIRI5C_UART_TX_BREAK_EN
  assign w_break = send_break;
`else
  assign w_break = 1'b0;
`endif

  assign w_start = (r_state == S_IDLE) && !w_empty && !w_break &&
                   !((w_ctrl.flow_ctrl == UART_FLOW_CTRL_ON) && cts);

  assign w_bit_end = (r_cnt == r_baud_last);

  airi5c_uart_fifo #(
    .ADDR_WIDTH (STACK_ADDR_WIDTH),
    .DATA_WIDTH (UART_DATA_WIDTH)
  ) u_fifo (
    .clk            (clk),
    .n_reset        (n_reset),
    .clear          (clear),
    .push           (push),
    .data_in        (data_in),
    .pop            (w_start),
    .data_out       (w_fifo_data),
    .size           (size),
    .empty          (w_empty),
    .full           (full),
    .overflow_error (overflow_error)
  );

  assign empty = w_empty;
  assign tx    = r_tx;
  assign busy  = r_busy;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_nbits     <= 4'd8;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_baud_last <= '0;
      r_stop_last <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          if (w_start) begin
            // Whole frame format is frozen here; later ctrl_reg writes wait a frame.
            r_state     <= S_START;
            r_tx        <= 1'b0;
            r_busy      <= 1'b1;
            r_shift     <= w_fifo_data;
            r_nbits     <= frame_data_bits(w_ctrl.data_bits);
            r_par_en    <= (w_ctrl.parity != UART_PARITY_NONE);
            r_par_bit   <= parity_bit(w_ctrl.parity, w_fifo_data,
                                      frame_data_bits(w_ctrl.data_bits));
            r_baud_last <= {1'b0, w_ctrl.baud_reg} - 25'd1;
            r_stop_last <= stop_cycles(w_ctrl.stop_bits, w_ctrl.baud_reg) - 25'd2;
          end else begin
            r_tx <= !w_break;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 25'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == r_nbits - 4'd1) begin
              if (r_par_en) begin
                r_state <= S_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 25'd1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 25'd1;
          end
        end

        S_STOP: begin
          // One cycle short: the following IDLE cycle is the last stop cycle.
          if (r_cnt == r_stop_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 25'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_airi5c_uart_tx.sv
// Directed bench for airi5c_uart_tx: frame shapes, back-to-back timing, flow control,
// overflow, clear and reset; break checks when AIRI5C_UART_TX_BREAK_EN is defined.
module tb_airi5c_uart_tx;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        clear;
  logic        tx;
  logic        cts;
  logic [31:0] ctrl_reg;
  logic        push;
  logic [8:0]  data_in;
  logic [5:0]  size;
  logic        empty;
  logic        full;
  logic        busy;
  logic        overflow_error;
`ifdef AIRI5C_UART_TX_BREAK_EN
  logic        send_break;
`endif

  int checks = 0;
  int errors = 0;

  logic       cap_tx   [0:1199];
  logic       cap_busy [0:1199];
  logic [5:0] cap_size [0:1199];

  always #5 clk = ~clk;

  airi5c_uart_tx #(.STACK_ADDR_WIDTH(5)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .clear          (clear),
    .tx             (tx),
    .cts            (cts),
    .ctrl_reg       (ctrl_reg),
    .push           (push),
    .data_in        (data_in),
    .size           (size),
    .empty          (empty),
    .full           (full),
    .busy           (busy),
    .overflow_error (overflow_error)
`ifdef AIRI5C_UART_TX_BREAK_EN
    ,
    .send_break     (send_break)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input int base, input int n);
    for (int i = base; i < base + n; i++) begin
      @(negedge clk);
      cap_tx[i]   = tx;
      cap_busy[i] = busy;
      cap_size[i] = size;
    end
  endtask

  // Observed value is the number of captured cycles that differ from the level.
  task automatic chk_level(input string tag, input int base, input int len, input logic lvl);
    int bad;
    bad = 0;
    for (int i = base; i < base + len; i++)
      if (cap_tx[i] !== lvl) bad++;
    chk($sformatf("%s_badcycles", tag), bad, 0);
  endtask

  task automatic chk_frame(input string tag, input int base, input int baud, input int nbits,
                           input logic [8:0] data, input logic par_en, input logic par,
                           input int stop_len);
    int pos;
    chk_level($sformatf("%s_start", tag), base, baud, 1'b0);
    pos = base + baud;
    for (int b = 0; b < nbits; b++) begin
      chk_level($sformatf("%s_d%0d", tag, b), pos, baud, data[b]);
      pos += baud;
    end
    if (par_en) begin
      chk_level($sformatf("%s_par", tag), pos, baud, par);
      pos += baud;
    end
    chk_level($sformatf("%s_stop", tag), pos, stop_len, 1'b1);
  endtask

  task automatic push_word(input logic [8:0] d);
    push    = 1'b1;
    data_in = d;
    @(negedge clk);
    push    = 1'b0;
  endtask

  initial begin
    n_reset  = 1'b0;
    clear    = 1'b0;
    cts      = 1'b0;
    ctrl_reg = 32'h0;
    push     = 1'b0;
    data_in  = 9'h0;
`ifdef AIRI5C_UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_size", size, 0);
    chk("rst_ovf", overflow_error, 0);
    n_reset = 1'b1;
    @(negedge clk);

    // 8N1, baud 16, 0x0A5
    ctrl_reg = {3'd3, 2'b00, 2'b00, 1'b0, 24'd16};
    push_word(9'h0A5);
    chk("t1_pre_tx", tx, 1);
    chk("t1_pre_empty", empty, 0);
    capture(0, 170);
    chk_frame("t1", 0, 16, 8, 9'h0A5, 1'b0, 1'b0, 16);
    chk("t1_busy_first", cap_busy[0], 1);
    chk("t1_busy_stop", cap_busy[158], 1);
    chk("t1_busy_fall", cap_busy[159], 0);
    chk_level("t1_idle", 160, 10, 1'b1);

    // 7E2: bit 7 set but outside the 7-bit frame, parity must ignore it
    ctrl_reg = {3'd2, 2'b01, 2'b10, 1'b0, 24'd16};
    push_word(9'h0C1);
    capture(0, 180);
    chk_frame("t2e", 0, 16, 7, 9'h0C1, 1'b1, 1'b0, 32);
    chk("t2e_busy_stop", cap_busy[174], 1);
    chk("t2e_busy_fall", cap_busy[175], 0);

    // 7O2
    ctrl_reg = {3'd2, 2'b10, 2'b10, 1'b0, 24'd16};
    push_word(9'h041);
    capture(0, 180);
    chk_frame("t2o", 0, 16, 7, 9'h041, 1'b1, 1'b1, 32);

    // 8N1.5, baud 32, three words held back by cts then released
    ctrl_reg = {3'd3, 2'b00, 2'b01, 1'b1, 24'd32};
    cts = 1'b1;
    push_word(9'h0F0);
    push_word(9'h033);
    push_word(9'h1FF);
    chk("t3_size3", size, 3);
    repeat (4) @(negedge clk);
    chk("t3_hold_tx", tx, 1);
    chk("t3_hold_busy", busy, 0);
    chk("t3_hold_size", size, 3);
    cts = 1'b0;
    capture(0, 1010);
    chk_frame("t3a", 0, 32, 8, 9'h0F0, 1'b0, 1'b0, 48);
    chk_frame("t3b", 336, 32, 8, 9'h033, 1'b0, 1'b0, 48);
    chk_frame("t3c", 672, 32, 8, 9'h1FF, 1'b0, 1'b0, 48);
    chk("t3_size_f0", cap_size[0], 2);
    chk("t3_size_gap", cap_size[335], 2);
    chk("t3_size_f1", cap_size[336], 1);
    chk("t3_size_f2", cap_size[672], 0);
    chk("t3_busy_gap", cap_busy[335], 0);
    chk("t3_busy_f1", cap_busy[336], 1);

    // flow control: stalled by cts, released, cts raised mid-frame
    ctrl_reg = {3'd3, 2'b00, 2'b00, 1'b1, 24'd16};
    cts = 1'b1;
    push_word(9'h05A);
    repeat (20) @(negedge clk);
    chk("t4_stall_tx", tx, 1);
    chk("t4_stall_busy", busy, 0);
    chk("t4_stall_size", size, 1);
    cts = 1'b0;
    capture(0, 40);
    cts = 1'b1;
    capture(40, 130);
    chk_frame("t4", 0, 16, 8, 9'h05A, 1'b0, 1'b0, 16);
    chk("t4_busy_fall", cap_busy[159], 0);

    // overflow and clear, line still stalled by cts
    for (int i = 0; i < 32; i++) push_word(9'(i));
    chk("t5_size_full", size, 32);
    chk("t5_full", full, 1);
    push    = 1'b1;
    data_in = 9'h1AA;
    #1;
    chk("t5_ovf_pulse", overflow_error, 1);
    @(negedge clk);
    push = 1'b0;
    #1;
    chk("t5_ovf_end", overflow_error, 0);
    chk("t5_size_kept", size, 32);
    chk("t5_busy", busy, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5_clear_empty", empty, 1);
    chk("t5_clear_size", size, 0);
    chk("t5_clear_full", full, 0);
    clear   = 1'b1;
    push    = 1'b1;
    data_in = 9'h055;
    @(negedge clk);
    clear = 1'b0;
    push  = 1'b0;
    chk("t5_push_clear", empty, 1);

    // reset during DATA
    cts      = 1'b0;
    ctrl_reg = {3'd3, 2'b00, 2'b00, 1'b0, 24'd16};
    push_word(9'h000);
    push_word(9'h000);
    repeat (40) @(negedge clk);
    chk("t6_pre_tx", tx, 0);
    chk("t6_pre_size", size, 1);
    n_reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_tx", tx, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_empty", empty, 1);
    n_reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_after_tx", tx, 1);
    chk("t6_after_busy", busy, 0);

`ifdef AIRI5C_UART_TX_BREAK_EN
    send_break = 1'b1;
    capture(0, 10);
    push_word(9'h0FF);
    capture(10, 30);
    chk_level("brk_low", 0, 40, 1'b0);
    chk("brk_busy", busy, 0);
    chk("brk_size", size, 1);
    send_break = 1'b0;
    @(negedge clk);
    chk("brk_rel_start", tx, 0);
    chk("brk_rel_busy", busy, 1);
    repeat (170) @(negedge clk);
    chk("brk_done_tx", tx, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
